timers_t1_ctrl: RTL and testbench
=================================

TIMERS_T1_CTRL -- requirements
Module: timers_t1_ctrl

Interface
Parameters:
REQ-001 ADDR_TCON, 8'h88, TCON SFR address (TF1 = bit 7, TR1 = bit 6; other bits read 0, writes ignored).
REQ-002 ADDR_TMOD, 8'h89, TMOD SFR address (GATE1 = bit 7, M1T1 = bit 5, M0T1 = bit 4; other bits read 0).
REQ-003 ADDR_TL1 8'h8B, ADDR_TH1 8'h8D, ADDR_TM1 8'h8E, byte addresses of the 24-bit count.

Ports:
REQ-004 timers_clock_i  in  1  sole clock; all state updates on rising edge.
REQ-005 timers_reset_i_b  in  1  synchronous, active-low reset.
REQ-006 sfr_addr_i  in  8  CPU SFR address.
REQ-007 sfr_wr_i, sfr_rd_i  in  1 each  one-cycle CPU write/read strobes; never asserted together.
REQ-008 sfr_wdata_i  in  8  CPU write data.
REQ-009 sfr_rdata_o  out  8  read data, registered, valid the cycle after sfr_rd_i.
REQ-010 int1_ack_i  in  1  interrupt-controller acknowledge of the Timer1 vector.
REQ-011 cnt_th_i, cnt_tm_i, cnt_tl_i  in  8 each  next count from the timer1 datapath.
REQ-012 cnt_tf_i  in  1  next TF1 from the timer1 datapath.
REQ-013 cnt_th_o, cnt_tm_o, cnt_tl_o  out  8 each  committed count fed back to the datapath.
REQ-014 tf1_o, tr1_o, gate1_o, m1t1_o, m0t1_o  out  1 each  committed control bits; tf1_o doubles as the interrupt request.
REQ-015 busy_o  out  1  high while a staged write or read snapshot is open.

Function
REQ-016 The count register {TH1,TM1,TL1} SHALL load the datapath next value every cycle unless a CPU commit overrides it.
REQ-017 FSM states: IDLE, WR_STAGED, RD_SNAP; one-hot or binary at implementer's choice.
REQ-018 Write TH1 or TM1: data goes to staging registers sth/stm, the count is unchanged, and the state SHALL become WR_STAGED.
REQ-019 Write TL1: {TH1,TM1,TL1} SHALL load {sth,stm,wdata} on that clock edge; the datapath value is discarded for that cycle; then IDLE.
REQ-020 Staging registers SHALL retain their values after a commit; a TL1-only write commits the old sth/stm.
REQ-021 Read TL1: sfr_rdata_o = TL1 next cycle, TH1/TM1 snapshot into shadow registers, state SHALL become RD_SNAP.
REQ-022 In RD_SNAP, a TH1/TM1 read SHALL return the shadow value; the count keeps running.
REQ-023 RD_SNAP SHALL exit to IDLE after a TH1 read or on any write.
REQ-024 In IDLE, a TH1/TM1 read SHALL return live values.
REQ-025 A write to any address other than TH1/TM1/TL1 SHALL NOT change the FSM state, except the RD_SNAP exit in REQ-023.
REQ-026 TCON/TMOD writes SHALL take effect on the next edge.
REQ-027 TF1 priority per cycle, high to low: CPU TCON write (bit 7 value), int1_ack_i (clears), cnt_tf_i.
REQ-028 If int1_ack_i and a datapath overflow (cnt_tf_i = 1 with committed tf1_o = 0) coincide, TF1 SHALL be 1.
REQ-029 Reads of unmapped addresses SHALL return 8'h00.
REQ-030 busy_o = (state != IDLE).
REQ-031 Count arithmetic is owned by the datapath; this block performs no increment or decrement and no width conversion.

Reset
REQ-032 With timers_reset_i_b = 0 at an edge, all outputs, count, staging, shadow, TCON and TMOD SHALL be 0, state IDLE, sfr_rdata_o 8'h00.
REQ-033 Reset SHALL override any simultaneous write, read, or acknowledge, and SHALL abort WR_STAGED/RD_SNAP with no commit.

Verification
REQ-034 Reset held 3 cycles, then released -> all outputs 0, busy_o = 0; first datapath value loads on the next edge.
REQ-035 Write TH1 = 8'h12, TM1 = 8'h34, TL1 = 8'h56 while mode 0 is running -> count 24'h123456 on the TL1 edge, busy_o high only between the TH1 write and the TL1 write.
REQ-036 Count 24'h00FFFF incrementing; read TL1, then read TM1 and TH1 two cycles later -> returned bytes are FF, FF, 00 (snapshot), and the live count has advanced.
REQ-037 tf1_o = 1, int1_ack_i pulse -> tf1_o = 0 next cycle; repeat with a coincident overflow -> tf1_o stays 1.
REQ-038 Write TH1 = 8'hAA, assert reset, then write TL1 = 8'h01 -> count = 24'h000001 (staging cleared, not AA).
REQ-039 TCON write 8'h40 in the same cycle as a datapath overflow -> tr1_o = 1, tf1_o = 0 (CPU write wins).

Source files
------------

// File: rtl/timers_t1_ctrl.sv
// Timer1 SFR front end: CPU access to TCON/TMOD and the 24-bit count, with
// staged multi-byte writes and a TL1-triggered read snapshot of TH1/TM1.
module timers_t1_ctrl #(
  parameter logic [7:0] ADDR_TCON = 8'h88,
  parameter logic [7:0] ADDR_TMOD = 8'h89,
  parameter logic [7:0] ADDR_TL1  = 8'h8B,
  parameter logic [7:0] ADDR_TH1  = 8'h8D,
  parameter logic [7:0] ADDR_TM1  = 8'h8E
) (
  input  logic       timers_clock_i,
  input  logic       timers_reset_i_b,
  input  logic [7:0] sfr_addr_i,
  input  logic       sfr_wr_i,
  input  logic       sfr_rd_i,
  input  logic [7:0] sfr_wdata_i,
  output logic [7:0] sfr_rdata_o,
  input  logic       int1_ack_i,
  input  logic [7:0] cnt_th_i,
  input  logic [7:0] cnt_tm_i,
  input  logic [7:0] cnt_tl_i,
  input  logic       cnt_tf_i,
  output logic [7:0] cnt_th_o,
  output logic [7:0] cnt_tm_o,
  output logic [7:0] cnt_tl_o,
  output logic       tf1_o,
  output logic       tr1_o,
  output logic       gate1_o,
  output logic       m1t1_o,
  output logic       m0t1_o,
  output logic       busy_o
);

  // state     | meaning
  // S_IDLE    | no access sequence open, TH1/TM1 reads return live count
  // S_WR_STAGED | TH1 and/or TM1 staged, waiting for the committing TL1 write
  // S_RD_SNAP | TL1 was read, TH1/TM1 reads return the snapshot
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WR_STAGED = 2'd1,
    S_RD_SNAP   = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_th, r_tm, r_tl;
  logic [7:0] r_sth, r_stm;
  logic [7:0] r_shh, r_shm;
  logic [7:0] r_rdata;
  logic       r_tf1, r_tr1, r_gate1, r_m1t1, r_m0t1;

  logic       w_wr_th, w_wr_tm, w_wr_tl, w_wr_tcon, w_wr_tmod;
  logic       w_rd_th, w_rd_tl;
  logic [7:0] w_rdata;

  assign w_wr_th   = sfr_wr_i && (sfr_addr_i == ADDR_TH1);
  assign w_wr_tm   = sfr_wr_i && (sfr_addr_i == ADDR_TM1);
  assign w_wr_tl   = sfr_wr_i && (sfr_addr_i == ADDR_TL1);
  assign w_wr_tcon = sfr_wr_i && (sfr_addr_i == ADDR_TCON);
  assign w_wr_tmod = sfr_wr_i && (sfr_addr_i == ADDR_TMOD);
  assign w_rd_th   = sfr_rd_i && (sfr_addr_i == ADDR_TH1);
  assign w_rd_tl   = sfr_rd_i && (sfr_addr_i == ADDR_TL1);

  always_comb begin
    w_rdata = 8'h00;
    if (sfr_addr_i == ADDR_TCON)
      w_rdata = {r_tf1, r_tr1, 6'b000000};
    else if (sfr_addr_i == ADDR_TMOD)
      w_rdata = {r_gate1, 1'b0, r_m1t1, r_m0t1, 4'b0000};
    else if (sfr_addr_i == ADDR_TL1)
      w_rdata = r_tl;
    else if (sfr_addr_i == ADDR_TM1)
      w_rdata = (r_state == S_RD_SNAP) ? r_shm : r_tm;
    else if (sfr_addr_i == ADDR_TH1)
      w_rdata = (r_state == S_RD_SNAP) ? r_shh : r_th;
  end

  always_ff @(posedge timers_clock_i) begin
    if (!timers_reset_i_b) begin
      r_state <= S_IDLE;
      r_th    <= 8'h00;
      r_tm    <= 8'h00;
      r_tl    <= 8'h00;
      r_sth   <= 8'h00;
      r_stm   <= 8'h00;
      r_shh   <= 8'h00;
      r_shm   <= 8'h00;
      r_rdata <= 8'h00;
      r_tf1   <= 1'b0;
      r_tr1   <= 1'b0;
      r_gate1 <= 1'b0;
      r_m1t1  <= 1'b0;
      r_m0t1  <= 1'b0;
    end else begin
      // A TL1 write commits the whole count; otherwise the datapath owns it.
      if (w_wr_tl) begin
        r_th <= r_sth;
        r_tm <= r_stm;
        r_tl <= sfr_wdata_i;
      end else begin
        r_th <= cnt_th_i;
        r_tm <= cnt_tm_i;
        r_tl <= cnt_tl_i;
      end

      if (w_wr_th) r_sth <= sfr_wdata_i;
      if (w_wr_tm) r_stm <= sfr_wdata_i;

      if (sfr_rd_i) r_rdata <= w_rdata;
      if (w_rd_tl) begin
        r_shh <= r_th;
        r_shm <= r_tm;
      end

      // An ack only loses to a fresh overflow, never to an already-set flag.
      if (w_wr_tcon) begin
        r_tf1 <= sfr_wdata_i[7];
        r_tr1 <= sfr_wdata_i[6];
      end else if (int1_ack_i) begin
        r_tf1 <= cnt_tf_i & ~r_tf1;
      end else begin
        r_tf1 <= cnt_tf_i;
      end

      if (w_wr_tmod) begin
        r_gate1 <= sfr_wdata_i[7];
        r_m1t1  <= sfr_wdata_i[5];
        r_m0t1  <= sfr_wdata_i[4];
      end

      case (r_state)
        S_IDLE: begin
          if (w_wr_th || w_wr_tm) r_state <= S_WR_STAGED;
          else if (w_rd_tl)       r_state <= S_RD_SNAP;
        end
        S_WR_STAGED: begin
          if (w_wr_tl)      r_state <= S_IDLE;
          else if (w_rd_tl) r_state <= S_RD_SNAP;
        end
        S_RD_SNAP: begin
          if (w_wr_th || w_wr_tm) r_state <= S_WR_STAGED;
          else if (sfr_wr_i)      r_state <= S_IDLE;
          else if (w_rd_th)       r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sfr_rdata_o = r_rdata;
  assign cnt_th_o    = r_th;
  assign cnt_tm_o    = r_tm;
  assign cnt_tl_o    = r_tl;
  assign tf1_o       = r_tf1;
  assign tr1_o       = r_tr1;
  assign gate1_o     = r_gate1;
  assign m1t1_o      = r_m1t1;
  assign m0t1_o      = r_m0t1;
  assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_timers_t1_ctrl.sv
// Directed bench for timers_t1_ctrl; a tiny incrementing datapath model
// closes the count loop so snapshot and commit behaviour can be observed.
module tb_timers_t1_ctrl;

  localparam logic [7:0] A_TCON = 8'h88;
  localparam logic [7:0] A_TMOD = 8'h89;
  localparam logic [7:0] A_TL1  = 8'h8B;
  localparam logic [7:0] A_TH1  = 8'h8D;
  localparam logic [7:0] A_TM1  = 8'h8E;

  logic       clk_sys = 1'b0;
  logic       rst_b;
  logic [7:0] sfr_addr;
  logic       sfr_wr, sfr_rd;
  logic [7:0] sfr_wdata;
  logic [7:0] sfr_rdata;
  logic       int1_ack;
  logic [7:0] cnt_th_i, cnt_tm_i, cnt_tl_i;
  logic       cnt_tf_i;
  logic [7:0] cnt_th_o, cnt_tm_o, cnt_tl_o;
  logic       tf1, tr1, gate1, m1t1, m0t1, busy;

  logic       inc_en;
  logic       ovf;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk_sys = ~clk_sys;

  // Datapath stand-in: counts up when enabled, holds TF1 unless overflow forced.
  assign {cnt_th_i, cnt_tm_i, cnt_tl_i} = {cnt_th_o, cnt_tm_o, cnt_tl_o} + {23'd0, inc_en};
  assign cnt_tf_i = tf1 | ovf;

  timers_t1_ctrl dut (
    .timers_clock_i   (clk_sys),
    .timers_reset_i_b (rst_b),
    .sfr_addr_i       (sfr_addr),
    .sfr_wr_i         (sfr_wr),
    .sfr_rd_i         (sfr_rd),
    .sfr_wdata_i      (sfr_wdata),
    .sfr_rdata_o      (sfr_rdata),
    .int1_ack_i       (int1_ack),
    .cnt_th_i         (cnt_th_i),
    .cnt_tm_i         (cnt_tm_i),
    .cnt_tl_i         (cnt_tl_i),
    .cnt_tf_i         (cnt_tf_i),
    .cnt_th_o         (cnt_th_o),
    .cnt_tm_o         (cnt_tm_o),
    .cnt_tl_o         (cnt_tl_o),
    .tf1_o            (tf1),
    .tr1_o            (tr1),
    .gate1_o          (gate1),
    .m1t1_o           (m1t1),
    .m0t1_o           (m0t1),
    .busy_o           (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
    sfr_addr  = a;
    sfr_wdata = d;
    sfr_wr    = 1'b1;
    tick();
    sfr_wr    = 1'b0;
  endtask

  task automatic sfr_read(input logic [7:0] a);
    sfr_addr = a;
    sfr_rd   = 1'b1;
    tick();
    sfr_rd   = 1'b0;
  endtask

  function automatic logic [23:0] count();
    return {cnt_th_o, cnt_tm_o, cnt_tl_o};
  endfunction

  initial begin
    rst_b = 1'b0; sfr_addr = 8'h00; sfr_wr = 1'b0; sfr_rd = 1'b0;
    sfr_wdata = 8'h00; int1_ack = 1'b0; inc_en = 1'b1; ovf = 1'b0;

    // reset held three cycles
    repeat (3) tick();
    rst_b = 1'b1;
    check_val("rst_count", count(), 24'h000000);
    check_val("rst_ctrl", {tf1, tr1, gate1, m1t1, m0t1}, 5'b00000);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_rdata", sfr_rdata, 8'h00);
    tick();
    check_val("first_load", count(), 24'h000001);

    // staged write while counting
    sfr_write(A_TH1, 8'h12);
    check_val("wr_th_busy", busy, 1'b1);
    sfr_write(A_TM1, 8'h34);
    check_val("wr_tm_busy", busy, 1'b1);
    sfr_write(A_TL1, 8'h56);
    check_val("commit_count", count(), 24'h123456);
    check_val("commit_busy", busy, 1'b0);
    tick();
    check_val("post_commit_run", count(), 24'h123457);
    sfr_write(A_TL1, 8'h77);
    check_val("tl_only_commit", count(), 24'h123477);
    check_val("tl_only_busy", busy, 1'b0);

    // snapshot read across a TM1->TH1 carry
    sfr_write(A_TH1, 8'h00);
    sfr_write(A_TM1, 8'hFF);
    sfr_write(A_TL1, 8'hFF);
    check_val("load_00ffff", count(), 24'h00FFFF);
    sfr_read(A_TL1);
    check_val("rd_tl", sfr_rdata, 8'hFF);
    check_val("snap_busy", busy, 1'b1);
    tick();
    tick();
    sfr_read(A_TM1);
    check_val("rd_tm_shadow", sfr_rdata, 8'hFF);
    check_val("snap_busy2", busy, 1'b1);
    sfr_read(A_TH1);
    check_val("rd_th_shadow", sfr_rdata, 8'h00);
    check_val("snap_exit", busy, 1'b0);
    check_val("live_advanced", count(), 24'h010004);
    sfr_read(A_TH1);
    check_val("rd_th_live", sfr_rdata, 8'h01);

    // TF1 acknowledge and coincident overflow
    inc_en = 1'b0;
    ovf = 1'b1;
    tick();
    ovf = 1'b0;
    check_val("tf_set", tf1, 1'b1);
    tick();
    check_val("tf_hold", tf1, 1'b1);
    int1_ack = 1'b1;
    tick();
    int1_ack = 1'b0;
    check_val("tf_ack_clear", tf1, 1'b0);
    tick();
    check_val("tf_stay_clear", tf1, 1'b0);
    int1_ack = 1'b1;
    ovf = 1'b1;
    tick();
    int1_ack = 1'b0;
    ovf = 1'b0;
    check_val("tf_ack_vs_ovf", tf1, 1'b1);

    // CPU TCON write beats overflow
    int1_ack = 1'b1;
    tick();
    int1_ack = 1'b0;
    check_val("tf_clear2", tf1, 1'b0);
    ovf = 1'b1;
    sfr_write(A_TCON, 8'h40);
    ovf = 1'b0;
    check_val("tcon_wr_tr1", tr1, 1'b1);
    check_val("tcon_wr_tf1", tf1, 1'b0);
    sfr_read(A_TCON);
    check_val("rd_tcon", sfr_rdata, 8'h40);

    // TMOD decode, readback masking, unmapped read
    sfr_write(A_TMOD, 8'hB0);
    check_val("tmod_bits", {gate1, m1t1, m0t1}, 3'b111);
    sfr_write(A_TMOD, 8'h4F);
    check_val("tmod_bits2", {gate1, m1t1, m0t1}, 3'b000);
    sfr_write(A_TMOD, 8'hFF);
    sfr_read(A_TMOD);
    check_val("rd_tmod", sfr_rdata, 8'hB0);
    sfr_read(8'h90);
    check_val("rd_unmapped", sfr_rdata, 8'h00);

    // reset aborts staged write and clears staging
    sfr_write(A_TH1, 8'hAA);
    check_val("stage_aa_busy", busy, 1'b1);
    sfr_write(A_TCON, 8'h40);
    check_val("other_wr_keeps_state", busy, 1'b1);
    rst_b = 1'b0;
    sfr_addr = A_TL1; sfr_wdata = 8'h99; sfr_wr = 1'b1;
    tick();
    sfr_wr = 1'b0;
    rst_b = 1'b1;
    check_val("rst_abort_busy", busy, 1'b0);
    check_val("rst_abort_count", count(), 24'h000000);
    check_val("rst_abort_tr1", tr1, 1'b0);
    sfr_write(A_TL1, 8'h01);
    check_val("post_rst_commit", count(), 24'h000001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
